// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers for the counter slice and its checkers.
//   GRAY_MAX_W      widest supported counter (WIDTH legal range is 2..16)
//   bin2gray(b)     binary -> Gray, operands zero-extended to GRAY_MAX_W
//   gray2bin(g)     Gray -> binary, prefix-XOR from MSB down
//   gray_max_bin(w) 2^w-1, the largest binary count for width w
//   gray_max_gray(w) 1 followed by w-1 zeros, the Gray code of 2^w-1
//   step_e          kind of state update taken on a clock edge
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 16;

  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_LOAD,
    STEP_INC,
    STEP_DEC,
    STEP_OVF,
    STEP_UNF
  } step_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits contribute nothing to the running XOR, so one
  // full-width function serves every WIDTH.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      acc                  = acc ^ g[GRAY_MAX_W-1-i];
      b[GRAY_MAX_W-1-i]    = acc;
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray_max_bin(input int unsigned width);
    logic [31:0] m;
    m = (32'd1 << width) - 32'd1;
    return m[GRAY_MAX_W-1:0];
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray_max_gray(input int unsigned width);
    return GRAY_MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/gray_counter_param_gray_to_bin.sv
// gray_to_bin: purely combinational Gray -> binary converter.
//   gray  input  [WIDTH-1:0]  Gray-coded value (every pattern is legal)
//   bin   output [WIDTH-1:0]  binary equivalent
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));
  end

endmodule

// File: rtl/gray_counter_param.sv
// gray_counter_param: registered Gray-code counter with direction, parallel
// load, binary mirror, overflow/underflow flags and a one-cycle wrap pulse.
//   Clk       in   clock, all state on posedge
//   Reset     in   synchronous, active-high, highest priority
//   En        in   count enable
//   Up        in   1 = increment, 0 = decrement
//   Load      in   parallel load strobe, priority over En
//   LoadVal   in   [WIDTH-1:0] Gray value to load
//   ClrFlags  in   clears sticky Overflow/Underflow (ignored if non-sticky)
//   Output    out  [WIDTH-1:0] registered Gray count
//   Binary    out  [WIDTH-1:0] registered binary equivalent of Output
//   Overflow  out  increment wrapped/saturated at max
//   Underflow out  decrement wrapped/saturated at 0
//   Wrap      out  one-cycle pulse on any wrap/saturation event
// Build option: define GRAY_CNT_SAT_EN to saturate at the ends instead of
// wrapping modulo 2^WIDTH.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH        = 3,
  parameter bit          STICKY_FLAGS = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] GRAY_MAX_BIN = WIDTH'(gray_max_bin(WIDTH));

  step_e            step;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             ovf_evt;
  logic             unf_evt;
  logic             ovf_d;
  logic             unf_d;

  gray_to_bin #(.WIDTH(WIDTH)) u_load_conv (
    .gray (LoadVal),
    .bin  (load_bin)
  );

  // Binary is the internal count B itself; Output is its registered Gray image.
  always_comb begin
    step = STEP_HOLD;
    if (Load) begin
      step = STEP_LOAD;
    end else if (En) begin
      if (Up) begin
        step = (Binary == GRAY_MAX_BIN) ? STEP_OVF : STEP_INC;
      end else begin
        step = (Binary == '0) ? STEP_UNF : STEP_DEC;
      end
    end
  end

  always_comb begin
    bin_d = Binary;
    case (step)
      STEP_LOAD: bin_d = load_bin;
      STEP_INC:  bin_d = Binary + WIDTH'(1);
      STEP_DEC:  bin_d = Binary - WIDTH'(1);
`ifdef GRAY_CNT_SAT_EN
      STEP_OVF:  bin_d = GRAY_MAX_BIN;
      STEP_UNF:  bin_d = '0;
`else
      STEP_OVF:  bin_d = '0;
      STEP_UNF:  bin_d = GRAY_MAX_BIN;
`endif
      default:   bin_d = Binary;
    endcase
  end

  always_comb begin
    gray_d  = (step == STEP_LOAD) ? LoadVal : WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
    ovf_evt = (step == STEP_OVF);
    unf_evt = (step == STEP_UNF);
    // Sticky: a same-edge event beats ClrFlags. Non-sticky: flags mirror the event.
    if (STICKY_FLAGS) begin
      ovf_d = ovf_evt | (Overflow  & ~ClrFlags);
      unf_d = unf_evt | (Underflow & ~ClrFlags);
    end else begin
      ovf_d = ovf_evt;
      unf_d = unf_evt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Output    <= '0;
      Binary    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Wrap      <= 1'b0;
    end else begin
      Output    <= gray_d;
      Binary    <= bin_d;
      Overflow  <= ovf_d;
      Underflow <= unf_d;
      Wrap      <= ovf_evt | unf_evt;
    end
  end

endmodule

// File: tb/tb_gray_counter_param.sv
`timescale 1ns/1ps
module tb_gray_counter_param;

`ifdef GRAY_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load, clr;
  logic [2:0] lv3;
  logic [3:0] lv4;
  logic [4:0] lv5;

  logic [2:0] o3, b3, o3n, b3n;
  logic [3:0] o4, b4;
  logic [4:0] o5, b5;
  logic       ov3, ud3, wr3, ov3n, ud3n, wr3n, ov4, ud4, wr4, ov5, ud5, wr5;

  gray_counter_param #(.WIDTH(3), .STICKY_FLAGS(1'b1)) u3 (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(lv3), .ClrFlags(clr),
    .Output(o3), .Binary(b3), .Overflow(ov3), .Underflow(ud3), .Wrap(wr3));
  gray_counter_param #(.WIDTH(3), .STICKY_FLAGS(1'b0)) u3n (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(lv3), .ClrFlags(clr),
    .Output(o3n), .Binary(b3n), .Overflow(ov3n), .Underflow(ud3n), .Wrap(wr3n));
  gray_counter_param #(.WIDTH(4), .STICKY_FLAGS(1'b1)) u4 (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(lv4), .ClrFlags(clr),
    .Output(o4), .Binary(b4), .Overflow(ov4), .Underflow(ud4), .Wrap(wr4));
  gray_counter_param #(.WIDTH(5), .STICKY_FLAGS(1'b1)) u5 (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(lv5), .ClrFlags(clr),
    .Output(o5), .Binary(b5), .Overflow(ov5), .Underflow(ud5), .Wrap(wr5));

  typedef struct {
    int unsigned edge_no;
    int unsigned dut;
    string       name;
    logic [15:0] o;
    logic [15:0] b;
    logic        ov;
    logic        ud;
    logic        wr;
    bit          ham;
  } exp_t;

  exp_t        q[$];
  int unsigned edge_cnt = 0;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always @(posedge clk) edge_cnt++;

  function automatic logic [4:0] g2b5(input logic [4:0] g);
    logic [4:0] r;
    r[4] = g[4];
    r[3] = r[4] ^ g[3];
    r[2] = r[3] ^ g[2];
    r[1] = r[2] ^ g[1];
    r[0] = r[1] ^ g[0];
    return r;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s edge=%0d got=%0h want=%0h", nm, fld, edge_cnt, act, req);
    end
  endtask

  // Monitor: checks every expectation due at the edge just taken.
  logic [15:0] prev5 = '0;
  always begin
    exp_t        e;
    logic [15:0] ao, ab;
    logic        aov, aud, awr;
    @(posedge clk);
    #2;
    while (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
      e = q.pop_front();
      case (e.dut)
        0:       begin ao = 16'(o3);  ab = 16'(b3);  aov = ov3;  aud = ud3;  awr = wr3;  end
        1:       begin ao = 16'(o3n); ab = 16'(b3n); aov = ov3n; aud = ud3n; awr = wr3n; end
        2:       begin ao = 16'(o4);  ab = 16'(b4);  aov = ov4;  aud = ud4;  awr = wr4;  end
        default: begin ao = 16'(o5);  ab = 16'(b5);  aov = ov5;  aud = ud5;  awr = wr5;  end
      endcase
      cmp(e.name, "edge",      16'(edge_cnt), 16'(e.edge_no));
      cmp(e.name, "Output",    ao,  e.o);
      cmp(e.name, "Binary",    ab,  e.b);
      cmp(e.name, "Overflow",  16'(aov), 16'(e.ov));
      cmp(e.name, "Underflow", 16'(aud), 16'(e.ud));
      cmp(e.name, "Wrap",      16'(awr), 16'(e.wr));
      if (e.dut == 3) begin
        cmp(e.name, "bin_mirror", 16'(b5), 16'(g2b5(o5)));
        if (e.ham) cmp(e.name, "hamming_le1", 16'($countones(16'(o5) ^ prev5) <= 1), 16'd1);
      end
    end
    prev5 = 16'(o5);
  end

  task automatic set_in(input logic r, input logic e, input logic u, input logic l, input logic c);
    rst = r; en = e; up = u; load = l; clr = c;
  endtask

  task automatic expect_out(input int unsigned d, input string nm, input logic [15:0] o,
                            input logic [15:0] b, input logic ov, input logic ud,
                            input logic wr, input bit ham);
    exp_t e;
    e.edge_no = edge_cnt + 1; e.dut = d; e.name = nm;
    e.o = o; e.b = b; e.ov = ov; e.ud = ud; e.wr = wr; e.ham = ham;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [2:0] g3 [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [4:0] mb;
  logic       mo, mu, mw, wu, wd, r_r, r_e, r_u, r_l, r_c;

  initial begin
    #2_000_000;
    $display("FAIL watchdog edge=%0d got=timeout want=finish", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    lv3 = '0; lv4 = '0; lv5 = '0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(0, "reset3",  16'h0, 16'h0, 0, 0, 0, 0);
    expect_out(1, "reset3n", 16'h0, 16'h0, 0, 0, 0, 0);
    expect_out(2, "reset4",  16'h0, 16'h0, 0, 0, 0, 0);
    tick();

    // Eight increments: full Gray cycle, wrap (or saturate) on the 8th edge.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) begin
        expect_out(0, "count_up",  16'(g3[k]), 16'(k), 0, 0, 0, 0);
        expect_out(1, "count_upn", 16'(g3[k]), 16'(k), 0, 0, 0, 0);
      end else begin
        expect_out(0, "wrap_up",  SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 1, 0, 1, 0);
        expect_out(1, "wrap_upn", SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 1, 0, 1, 0);
      end
      tick();
    end

    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(0, "sticky_hold", SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 1, 0, 0, 0);
    expect_out(1, "pulse_drop",  SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 0, 0, 0, 0);
    tick();

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "clr_ovf", SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 0, 0, 0, 0);
    tick();

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(0, "reset_again", 16'h0, 16'h0, 0, 0, 0, 0);
    tick();

    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(0, "wrap_down", SAT ? 16'h0 : 16'h4, SAT ? 16'h0 : 16'h7, 0, 1, 1, 0);
    tick();

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "clr_udf", SAT ? 16'h0 : 16'h4, SAT ? 16'h0 : 16'h7, 0, 0, 0, 0);
    tick();

    // Load beats a simultaneous En; then one increment from the loaded value.
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    lv4 = 4'b1101;
    expect_out(2, "load4", 16'hD, 16'h9, 0, 0, 0, 0);
    tick();

    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out(2, "load4_inc", 16'hF, 16'hA, 0, 0, 0, 0);
    tick();

    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lv3 = 3'b110;
    expect_out(0, "load_mid", 16'h6, 16'h4, 0, 0, 0, 0);
    tick();

    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_out(0, "reset_priority", 16'h0, 16'h0, 0, 0, 0, 0);
    tick();

    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lv3 = 3'b100;
    expect_out(0, "load_max",  16'h4, 16'h7, 0, 0, 0, 0);
    expect_out(1, "load_maxn", 16'h4, 16'h7, 0, 0, 0, 0);
    tick();

    // Wrap and ClrFlags on the same edge: the set wins.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_out(0, "wrap_vs_clr",  SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 1, 0, 1, 0);
    expect_out(1, "wrap_vs_clrn", SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 1, 0, 1, 0);
    tick();

    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(0, "set_won",    SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 1, 0, 0, 0);
    expect_out(1, "one_cycle",  SAT ? 16'h4 : 16'h0, SAT ? 16'h7 : 16'h0, 0, 0, 0, 0);
    tick();

    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    lv3 = 3'b011;
    expect_out(0, "load_keeps_flag", 16'h3, 16'h2, 1, 0, 0, 0);
    tick();

    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(0, "dir_change", 16'h1, 16'h1, 1, 0, 0, 0);
    tick();

    // Random phase on the WIDTH=5 instance against a behavioural model.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mb = '0; mo = 0; mu = 0; mw = 0;
    expect_out(3, "rand_reset", 16'h0, 16'h0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 10000; n++) begin
      r_r = ($urandom_range(0, 499) == 0);
      r_e = 1'($urandom_range(0, 1));
      r_u = 1'($urandom_range(0, 1));
      r_l = ($urandom_range(0, 7) == 0);
      r_c = ($urandom_range(0, 3) == 0);
      lv5 = 5'($urandom);
      set_in(r_r, r_e, r_u, r_l, r_c);
      if (r_r) begin
        mb = '0; mo = 0; mu = 0; mw = 0;
      end else begin
        wu = 0; wd = 0;
        if (r_l) begin
          mb = g2b5(lv5);
        end else if (r_e) begin
          if (r_u) begin
            if (mb == 5'd31) begin wu = 1; mb = SAT ? 5'd31 : 5'd0; end
            else mb = mb + 5'd1;
          end else begin
            if (mb == 5'd0) begin wd = 1; mb = SAT ? 5'd0 : 5'd31; end
            else mb = mb - 5'd1;
          end
        end
        mo = wu | (mo & ~r_c);
        mu = wd | (mu & ~r_c);
        mw = wu | wd;
      end
      expect_out(3, "rand5", 16'(mb ^ (mb >> 1)), 16'(mb), mo, mu, mw, !r_r && !r_l);
      tick();
    end

    repeat (2) tick();
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d want=0 pending", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised, registered Gray-code counter, WIDTH bits wide.
- Adds count direction, parallel load, a registered binary mirror, and separate sticky overflow/underflow flags.
- Also produces a one-cycle wrap pulse.
- Used as a pointer/sequence source wherever single-bit-change outputs are needed, e.g. clock-domain-crossing pointers and the lab sequence generators.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16; sequence length 2^WIDTH.
- STICKY_FLAGS, 1, 1: Overflow/Underflow hold until Reset or ClrFlags; 0: they are single-cycle pulses.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high; highest priority.
- En  input  1  count enable.
- Up  input  1  direction; 1 = increment, 0 = decrement; sampled only when En=1.
- Load  input  1  parallel load strobe; priority over En.
- LoadVal  input  WIDTH  Gray-coded value to load; every WIDTH-bit pattern is a legal Gray code.
- ClrFlags  input  1  clears Overflow/Underflow when STICKY_FLAGS=1; ignored when STICKY_FLAGS=0.
- Output  output  WIDTH  registered Gray count.
- Binary  output  WIDTH  registered binary equivalent of Output; updated on the same edge.
- Overflow  output  1  increment wrapped (or saturated) from max.
- Underflow  output  1  decrement wrapped (or saturated) from 0.
- Wrap  output  1  one-cycle pulse on any wrap/saturation event.

Behaviour:
- Reset=1 at a clock edge sets Output=0, Binary=0, Overflow=0, Underflow=0, Wrap=0.
- Reset overrides Load, En and ClrFlags, including mid-sequence.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- Internal state is a binary count B; Output = B ^ (B>>1), registered alongside B.
- Priority per edge: Reset > Load > En. ClrFlags is evaluated in parallel with Load/En.
- Load=1:
  - B <= gray2bin(LoadVal), Output <= LoadVal.
  - Flags unchanged except for ClrFlags; Wrap <= 0.
  - En is ignored that cycle.
- En=1, Up=1, B != 2^WIDTH-1: B <= B+1. Output changes in exactly one bit.
- En=1, Up=1, B == 2^WIDTH-1 (Output = 1 followed by WIDTH-1 zeros, e.g. 100 for WIDTH=3):
  - B <= 0, Output <= 0.
  - Overflow <= 1, Wrap <= 1 for one cycle.
- En=1, Up=0, B != 0: B <= B-1.
- En=1, Up=0, B == 0:
  - B <= 2^WIDTH-1.
  - Underflow <= 1, Wrap <= 1 for one cycle.
- En=0 and Load=0: state holds; Wrap <= 0.
- Flag update, STICKY_FLAGS=1:
  - Flag set by a wrap event; cleared by ClrFlags.
  - If a wrap and ClrFlags occur on the same edge, set wins (flag=1).
- Flag update, STICKY_FLAGS=0: Overflow/Underflow equal Wrap qualified by direction, i.e. high for exactly one cycle.
- Arithmetic is modulo 2^WIDTH; there are no X-assignments and no default-to-X case arms.
- Direction may change on any cycle. The next step is taken from the current value, still a single-bit Gray change.

Optional Feature:
- Macro GRAY_CNT_SAT_EN.
- Defined: saturating mode.
  - Increment at max holds B=2^WIDTH-1; decrement at 0 holds B=0.
  - Overflow/Underflow and Wrap still assert exactly as for a wrap event.
- Undefined: modulo wrap as described in Behaviour.

Decomposition:
- Package gray_pkg holds:
  - functions bin2gray(WIDTH) and gray2bin(WIDTH), the latter a prefix-XOR from MSB down;
  - localparam helpers GRAY_MAX_BIN = 2^WIDTH-1 and GRAY_MAX_GRAY = 1 followed by WIDTH-1 zeros.
- One sub-module, gray_to_bin: purely combinational, parametrised by WIDTH, used for the LoadVal conversion.
- Also instantiable by the team's testbench checkers.

Test Plan:
- WIDTH=3, reset, then En=1, Up=1 for 8 cycles:
  - Output sequence 000,001,011,010,110,111,101,100,000 and Binary 0..7 then 0.
  - Overflow=1 and Wrap=1 only after the 8th edge; Wrap=0 on the next edge.
- WIDTH=3, from 000, En=1, Up=0 for one cycle: Output=100, Binary=7, Underflow=1, Wrap=1.
  - Then ClrFlags=1: Underflow=0.
- WIDTH=4, Load=1, LoadVal=1101 with En=1 simultaneously: Output=1101, Binary=1001.
  - Next edge, En=1, Up=1: Output=1111, Binary=1010.
- WIDTH=3, mid-count at 110, Reset=1 with Load=1 and En=1: all outputs 0 next edge.
  - Also: wrap at 100 with ClrFlags=1 on the same edge gives Overflow=1.
- WIDTH=3, STICKY_FLAGS=0: wrap from 100 gives Overflow high exactly one cycle.
  - With GRAY_CNT_SAT_EN defined, incrementing at 100 holds Output=100 with Overflow=1.
- Random En/Up/Load for 10k cycles, WIDTH=5: every non-load, non-reset edge changes Output by Hamming distance ≤1; Binary == gray2bin(Output) at all times.
